// File: rtl/control_cmd_dispatch_pkg.sv
// Opcodes and FSM state type for the UART command front end.
package control_cmd_dispatch_pkg;
  localparam logic [7:0] OP_FRAME  = 8'h46;
  localparam logic [7:0] OP_BRIGHT = 8'h42;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FRAME_START,
    ST_FRAME_PAYLOAD,
    ST_WAIT_DONE,
    ST_BRIGHT_ARG
  } cmd_state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction
endpackage

// File: rtl/params_pkg.sv
// Display geometry shared across the control path; frame payload sizes derive from it.
package params;
  localparam int unsigned PIXEL_WIDTH     = 8;
  localparam int unsigned PIXEL_HEIGHT    = 8;
  localparam int unsigned BYTES_PER_PIXEL = 3;
endpackage

// File: rtl/control_cmd_dispatch_timer.sv
// cmd_timeout_timer: idle-cycle watchdog for an in-progress command.
// Only exists in CMD_TIMEOUT_EN builds; the default build has no timer at all.
`ifdef CMD_TIMEOUT_EN
module cmd_timeout_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_run,
  output logic o_expired
);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] r_cnt;
  logic          w_at_limit;

  assign w_at_limit = (r_cnt == TW'(TIMEOUT_CYCLES));
  assign o_expired  = i_run && w_at_limit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                   r_cnt <= '0;
    else if (i_clear)             r_cnt <= '0;
    else if (i_run && !w_at_limit) r_cnt <= r_cnt + TW'(1);
  end
endmodule
`endif

// File: rtl/control_cmd_dispatch.sv
// Command front end: decodes opcodes from the UART byte stream and routes payload to readframe.
// Optional idle-abort watchdog enabled by defining CMD_TIMEOUT_EN.
module control_cmd_dispatch
  import control_cmd_dispatch_pkg::*;
#(
  parameter int unsigned PAYLOAD_BYTES  = params::PIXEL_WIDTH * params::PIXEL_HEIGHT * params::BYTES_PER_PIXEL,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  output logic [7:0]  o_rf_data,
  output logic        o_rf_enable,
  output logic        o_rf_reset,
  input  logic        i_rf_done,
  output logic [7:0]  o_brightness,
  output logic        o_busy,
  output logic [7:0]  o_err_count,
  output logic [15:0] o_frame_count
);
  localparam int unsigned CW = $clog2(PAYLOAD_BYTES + 1);

  cmd_state_t    r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic          r_rst_hold;
  logic          w_expired;

  logic [7:0]  r_rf_data, w_rf_data;
  logic        r_rf_enable, w_rf_enable;
  logic        r_rf_reset, w_rf_reset;
  logic [7:0]  r_brightness, w_brightness;
  logic        r_busy, w_busy;
  logic [7:0]  r_err_count;
  logic [15:0] r_frame_count;
  logic        w_err_inc, w_frame_inc;

`ifdef CMD_TIMEOUT_EN
  logic w_tmr_clear, w_tmr_run;
  assign w_tmr_clear = i_rx_valid || (w_next != r_state);
  assign w_tmr_run   = (r_state == ST_FRAME_PAYLOAD) || (r_state == ST_WAIT_DONE) ||
                       (r_state == ST_BRIGHT_ARG);

  cmd_timeout_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk       (clk),
    .reset     (reset),
    .i_clear   (w_tmr_clear),
    .i_run     (w_tmr_run),
    .o_expired (w_expired)
  );
`else
  assign w_expired = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (w_expired) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_rx_valid && i_rx_data == OP_FRAME)       w_next = ST_FRAME_START;
          else if (i_rx_valid && i_rx_data == OP_BRIGHT) w_next = ST_BRIGHT_ARG;
        end
        ST_FRAME_START:   w_next = ST_FRAME_PAYLOAD;
        ST_FRAME_PAYLOAD: if (i_rx_valid && r_cnt == CW'(PAYLOAD_BYTES - 1)) w_next = ST_WAIT_DONE;
        ST_WAIT_DONE:     if (i_rf_done) w_next = ST_IDLE;
        ST_BRIGHT_ARG:    if (i_rx_valid) w_next = ST_IDLE;
        default:          w_next = ST_IDLE;
      endcase
    end
  end

  // Next values for the registered outputs; the opcode byte never reaches rf_data.
  always_comb begin
    w_rf_data    = r_rf_data;
    w_rf_enable  = 1'b0;
    w_brightness = r_brightness;
    w_err_inc    = 1'b0;
    w_frame_inc  = 1'b0;
    if (w_expired) begin
      w_err_inc = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE:
          if (i_rx_valid && i_rx_data != OP_FRAME && i_rx_data != OP_BRIGHT) w_err_inc = 1'b1;
        ST_FRAME_START:
          if (i_rx_valid) w_err_inc = 1'b1;
        ST_FRAME_PAYLOAD:
          if (i_rx_valid) begin
            w_rf_data   = i_rx_data;
            w_rf_enable = 1'b1;
          end
        ST_WAIT_DONE: begin
          if (i_rx_valid) w_err_inc   = 1'b1;
          if (i_rf_done)  w_frame_inc = 1'b1;
        end
        ST_BRIGHT_ARG:
          if (i_rx_valid) w_brightness = i_rx_data;
        default: ;
      endcase
    end
    w_rf_reset = r_rst_hold || (w_next == ST_FRAME_START) || w_expired;
    w_busy     = (w_next != ST_IDLE);
  end

  // r_rst_hold keeps readframe in reset through the first edge after async release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rst_hold    <= 1'b1;
      r_cnt         <= '0;
      r_rf_data     <= 8'h00;
      r_rf_enable   <= 1'b0;
      r_rf_reset    <= 1'b1;
      r_brightness  <= 8'hFF;
      r_busy        <= 1'b0;
      r_err_count   <= 8'h00;
      r_frame_count <= 16'h0000;
    end else begin
      r_rst_hold   <= 1'b0;
      r_rf_data    <= w_rf_data;
      r_rf_enable  <= w_rf_enable;
      r_rf_reset   <= w_rf_reset;
      r_brightness <= w_brightness;
      r_busy       <= w_busy;
      if (r_state == ST_FRAME_START)                   r_cnt <= '0;
      else if (r_state == ST_FRAME_PAYLOAD && i_rx_valid) r_cnt <= r_cnt + CW'(1);
      if (w_err_inc)   r_err_count   <= sat_inc8(r_err_count);
      if (w_frame_inc) r_frame_count <= r_frame_count + 16'd1;
    end
  end

  assign o_rf_data     = r_rf_data;
  assign o_rf_enable   = r_rf_enable;
  assign o_rf_reset    = r_rf_reset;
  assign o_brightness  = r_brightness;
  assign o_busy        = r_busy;
  assign o_err_count   = r_err_count;
  assign o_frame_count = r_frame_count;
endmodule

// File: tb/tb_control_cmd_dispatch.sv
// Self-checking bench for control_cmd_dispatch; forwarded bytes are tracked on a scoreboard.
module tb_control_cmd_dispatch;
  localparam int unsigned PB = 6;
  localparam int unsigned TO = 20;

  logic        clk, reset;
  logic [7:0]  rx_data;
  logic        rx_valid, rf_done;
  logic [7:0]  rf_data, brightness, err_count;
  logic        rf_enable, rf_reset, busy;
  logic [15:0] frame_count;

  typedef struct { logic [7:0] data; int cyc; } sb_t;
  sb_t sb[$];
  int  cyc = 0;
  int  n_chk = 0;
  int  n_fail = 0;

  control_cmd_dispatch #(.PAYLOAD_BYTES(PB), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .i_rx_data(rx_data), .i_rx_valid(rx_valid),
    .o_rf_data(rf_data), .o_rf_enable(rf_enable), .o_rf_reset(rf_reset),
    .i_rf_done(rf_done),
    .o_brightness(brightness), .o_busy(busy),
    .o_err_count(err_count), .o_frame_count(frame_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  // Every rf_enable pulse must match the oldest pushed byte, one cycle after its rx_valid.
  always @(negedge clk) begin
    if (reset === 1'b1 && rf_enable === 1'b1) begin
      n_chk++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: rf_enable with data %h, expected no pulse", rf_data);
      end else begin
        sb_t e;
        e = sb.pop_front();
        if (rf_data !== e.data || cyc != e.cyc) begin
          n_fail++;
          $display("FAIL sb_byte: got %h at cyc %0d, expected %h at cyc %0d", rf_data, cyc, e.data, e.cyc);
        end
      end
    end
  end

  // Called at a negedge; leaves at the next negedge with rx_valid low.
  task automatic rx(input logic [7:0] b, input bit fwd);
    rx_data  = b;
    rx_valid = 1'b1;
    if (fwd) sb.push_back('{data: b, cyc: cyc + 1});
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic done_pulse();
    rf_done = 1'b1;
    @(negedge clk);
    rf_done = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] base);
    rx(8'h46, 0);
    @(negedge clk);
    for (int i = 0; i < PB; i++) rx(base + 8'(i), 1);
  endtask

  task automatic test_reset();
    reset = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; rf_done = 1'b0;
    @(negedge clk);
    n_chk++; if (rf_data !== 8'h00) begin n_fail++; $display("FAIL rst_rf_data: got %h exp 00", rf_data); end
    n_chk++; if (rf_enable !== 1'b0) begin n_fail++; $display("FAIL rst_rf_enable: got %b exp 0", rf_enable); end
    n_chk++; if (rf_reset !== 1'b1) begin n_fail++; $display("FAIL rst_rf_reset: got %b exp 1", rf_reset); end
    n_chk++; if (brightness !== 8'hFF) begin n_fail++; $display("FAIL rst_brightness: got %h exp ff", brightness); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b exp 0", busy); end
    n_chk++; if (err_count !== 8'h00) begin n_fail++; $display("FAIL rst_err: got %h exp 00", err_count); end
    n_chk++; if (frame_count !== 16'h0) begin n_fail++; $display("FAIL rst_frames: got %h exp 0", frame_count); end
    reset = 1'b1;
    @(posedge clk); #1;
    n_chk++; if (rf_reset !== 1'b1) begin n_fail++; $display("FAIL rst_hold_edge1: got %b exp 1", rf_reset); end
    @(posedge clk); #1;
    n_chk++; if (rf_reset !== 1'b0) begin n_fail++; $display("FAIL rst_hold_edge2: got %b exp 0", rf_reset); end
  endtask

  task automatic test_frame();
    @(negedge clk);
    rx(8'h46, 0);
    n_chk++; if (rf_reset !== 1'b1) begin n_fail++; $display("FAIL frame_start_rst: got %b exp 1", rf_reset); end
    @(negedge clk);
    n_chk++; if (rf_reset !== 1'b0) begin n_fail++; $display("FAIL frame_rst_drop: got %b exp 0", rf_reset); end
    for (int i = 0; i < PB; i++) rx(8'(i), 1);
    @(negedge clk);
    n_chk++; if (rf_enable !== 1'b0 || rf_data !== 8'h05) begin n_fail++; $display("FAIL frame_hold: got en %b data %h exp 0 05", rf_enable, rf_data); end
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL frame_wait_busy: got %b exp 1", busy); end
    done_pulse();
    n_chk++; if (frame_count !== 16'd1) begin n_fail++; $display("FAIL frame_count: got %0d exp 1", frame_count); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL frame_idle: got %b exp 0", busy); end
  endtask

  task automatic test_bright();
    @(negedge clk);
    rx(8'h42, 0);
    rx(8'h3C, 0);
    n_chk++; if (brightness !== 8'h3C) begin n_fail++; $display("FAIL bright_val: got %h exp 3c", brightness); end
    rx(8'h7A, 0);
    n_chk++; if (err_count !== 8'd1) begin n_fail++; $display("FAIL bad_op_err: got %0d exp 1", err_count); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bad_op_idle: got %b exp 0", busy); end
  endtask

  task automatic test_wait_done_drop();
    @(negedge clk);
    send_frame(8'hA0);
    rx(8'h11, 0);
    n_chk++; if (err_count !== 8'd2) begin n_fail++; $display("FAIL wd_drop_err: got %0d exp 2", err_count); end
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL wd_drop_busy: got %b exp 1", busy); end
    done_pulse();
    n_chk++; if (frame_count !== 16'd2 || busy !== 1'b0) begin n_fail++; $display("FAIL wd_done: got frames %0d busy %b exp 2 0", frame_count, busy); end
  endtask

  task automatic test_back_to_back();
    // Byte during FRAME_START is dropped with an error; done with rx_valid both land.
    @(negedge clk);
    rx(8'h46, 0);
    rx(8'h99, 0);
    n_chk++; if (err_count !== 8'd3) begin n_fail++; $display("FAIL fs_violation_err: got %0d exp 3", err_count); end
    for (int i = 0; i < PB; i++) rx(8'h30 + 8'(i), 1);
    rf_done = 1'b1;
    rx(8'h22, 0);
    rf_done = 1'b0;
    n_chk++; if (err_count !== 8'd4) begin n_fail++; $display("FAIL done_rx_err: got %0d exp 4", err_count); end
    n_chk++; if (frame_count !== 16'd3 || busy !== 1'b0) begin n_fail++; $display("FAIL done_rx_frames: got %0d busy %b exp 3 0", frame_count, busy); end
    done_pulse();
    n_chk++; if (frame_count !== 16'd3) begin n_fail++; $display("FAIL idle_done_ignored: got %0d exp 3", frame_count); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    rx(8'h46, 0);
    @(negedge clk);
    for (int i = 0; i < 3; i++) rx(8'h50 + 8'(i), 1);
    #1;
    n_chk++; if (sb.size() != 0) begin n_fail++; $display("FAIL mid_sb_drained: got %0d pending exp 0", sb.size()); end
    reset = 1'b0;
    #1;
    n_chk++; if (rf_reset !== 1'b1 || rf_enable !== 1'b0 || rf_data !== 8'h00) begin n_fail++; $display("FAIL mid_rst_rf: got rst %b en %b data %h exp 1 0 00", rf_reset, rf_enable, rf_data); end
    n_chk++; if (busy !== 1'b0 || err_count !== 8'h0 || frame_count !== 16'h0 || brightness !== 8'hFF) begin n_fail++; $display("FAIL mid_rst_regs: got busy %b err %h frames %h bright %h exp 0 00 0000 ff", busy, err_count, frame_count, brightness); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    send_frame(8'hC0);
    done_pulse();
    n_chk++; if (frame_count !== 16'd1) begin n_fail++; $display("FAIL mid_refill_frames: got %0d exp 1", frame_count); end
  endtask

`ifdef CMD_TIMEOUT_EN
  task automatic test_timeout();
    int pulses = 0;
    do_reset();
    rx(8'h46, 0);
    @(negedge clk);
    rx(8'h01, 1);
    rx(8'h02, 1);
    for (int i = 0; i < 3 * TO; i++) begin
      @(negedge clk);
      if (rf_reset === 1'b1) pulses++;
    end
    n_chk++; if (pulses != 1) begin n_fail++; $display("FAIL to_pulses: got %0d exp 1", pulses); end
    n_chk++; if (err_count !== 8'd1 || busy !== 1'b0 || frame_count !== 16'd0) begin n_fail++; $display("FAIL to_state: got err %0d busy %b frames %0d exp 1 0 0", err_count, busy, frame_count); end
  endtask
`else
  task automatic test_no_timeout();
    do_reset();
    rx(8'h46, 0);
    @(negedge clk);
    rx(8'h01, 1);
    rx(8'h02, 1);
    for (int i = 0; i < 3 * TO; i++) @(negedge clk);
    n_chk++; if (busy !== 1'b1 || err_count !== 8'd0 || rf_reset !== 1'b0) begin n_fail++; $display("FAIL no_to_wait: got busy %b err %0d rst %b exp 1 0 0", busy, err_count, rf_reset); end
  endtask
`endif

  initial begin
    test_reset();
    test_frame();
    test_bright();
    test_wait_done_drop();
    test_back_to_back();
    test_reset_mid();
`ifdef CMD_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    @(negedge clk);
    n_chk++; if (sb.size() != 0) begin n_fail++; $display("FAIL sb_leftover: got %0d pending exp 0", sb.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
